nes_controller_poller: RTL and testbench



---
 rtl/nes_controller_poller.sv | 149 ++++++++++++++
 tb/tb_nes_controller_poller.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/nes_controller_poller.sv
// nes_controller_poller: polls two NES pads over a shared latch/pulse bus,
// deserialises each active-low report and publishes a registered
// 12-bit button vector plus a combined Start, with a one-cycle strobe.

// Per-pad datapath: input synchroniser, shift register and the button
// mapping of the report as it will look after the current capture.
module nes_pad_lane (
    input  logic       clk,
    input  logic       rst,
    input  logic       pad_data,
    input  logic       capture,
    output logic [5:0] btn_nxt,    // {left, right, up, down, A, B}, active-high
    output logic       start_nxt
);
    logic [1:0] sync;
    logic [7:0] shreg;
    logic [7:0] rpt_nxt;
    logic [1:0] unused_bits;

    // Bits arrive A first; shifting in at the MSB leaves bit k at index k
    // after eight captures.
    assign rpt_nxt = {sync[1], shreg[7:1]};

    // Select and the bit that drops off the end are never reported.
    assign unused_bits = {rpt_nxt[2], shreg[0]};

    assign btn_nxt   = ~{rpt_nxt[6], rpt_nxt[7], rpt_nxt[4], rpt_nxt[5], rpt_nxt[0], rpt_nxt[1]};
    assign start_nxt = ~rpt_nxt[3];

    // Two-flop synchroniser (idle-high) and capture shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= 2'b11;
            shreg <= 8'hFF;
        end else begin
            sync <= {sync[0], pad_data};
            if (capture) shreg <= rpt_nxt;
        end
    end
endmodule

module nes_controller_poller #(
    parameter int HALF_PERIOD = 300,
    parameter int POLL_PERIOD = 833333
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p1_data,
    input  logic        p2_data,
    output logic        ctrl_latch,
    output logic        ctrl_pulse,
    output logic [0:11] buttons,
    output logic        start_btn,
    output logic        sample_valid
);
    localparam int NUM_PADS = 2;
    localparam int TW = $clog2(2 * HALF_PERIOD);
    localparam int PW = $clog2(POLL_PERIOD);

    typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

    state_t                      state, state_nxt;
    logic [PW-1:0]               poll_cnt;
    logic                        poll_tick;
    logic [TW-1:0]               tmr;
    logic                        phase_end;
    logic [2:0]                  k;
    logic                        capture;
    logic                        publish;
    logic [NUM_PADS-1:0]         pad_data;
    logic [NUM_PADS-1:0][5:0]    btn_nxt;
    logic [NUM_PADS-1:0]         start_nxt;

    assign pad_data  = {p2_data, p1_data};
    assign poll_tick = (poll_cnt == PW'(POLL_PERIOD - 1));
    assign phase_end = (state == LATCH) ? (tmr == TW'(2 * HALF_PERIOD - 1))
                                        : (tmr == TW'(HALF_PERIOD - 1));
    assign publish   = capture && (k == 3'd7);

    nes_pad_lane u_lane [NUM_PADS-1:0] (
        .clk       (clk),
        .rst       (rst),
        .pad_data  (pad_data),
        .capture   (capture),
        .btn_nxt   (btn_nxt),
        .start_nxt (start_nxt)
    );

    // Free-running poll period counter, independent of the FSM.
    always_ff @(posedge clk) begin
        if (rst)            poll_cnt <= '0;
        else if (poll_tick) poll_cnt <= '0;
        else                poll_cnt <= poll_cnt + PW'(1);
    end

    // Next-state logic; capture fires on the final cycle of each LOW phase.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE:  if (poll_tick) state_nxt = LATCH;
            LATCH: if (phase_end) state_nxt = LOW;
            LOW: begin
                if (phase_end) begin
                    capture   = 1'b1;
                    state_nxt = (k == 3'd7) ? DONE : HIGH;
                end
            end
            HIGH:  if (phase_end) state_nxt = LOW;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, phase timer and bit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tmr   <= '0;
            k     <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || state == IDLE) tmr <= '0;
            else                                      tmr <= tmr + TW'(1);
            if (state == LATCH)                   k <= '0;
            else if (state == HIGH && phase_end)  k <= k + 3'd1;
        end
    end

    // Bus lines and results come straight from flops, decoded from the
    // next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_latch   <= 1'b0;
            ctrl_pulse   <= 1'b0;
            sample_valid <= 1'b0;
            buttons      <= '0;
            start_btn    <= 1'b0;
        end else begin
            ctrl_latch   <= (state_nxt == LATCH);
            ctrl_pulse   <= (state_nxt == HIGH);
            sample_valid <= (state_nxt == DONE);
            if (publish) begin
                for (int i = 0; i < NUM_PADS; i++) buttons[6*i +: 6] <= btn_nxt[i];
                start_btn <= |start_nxt;
            end
        end
    end
endmodule

// File: tb/tb_nes_controller_poller.sv
// Bench for nes_controller_poller: two behavioural NES pads respond to the
// latch/pulse bus; results and bus timing are checked against a model.
module tb_nes_controller_poller;
    logic        clk = 1'b0;
    logic        rst;
    logic        p1_data, p2_data;
    logic        ctrl_latch, ctrl_pulse, start_btn, sample_valid;
    logic [0:11] buttons;

    logic [7:0]  p1_rpt, p2_rpt;   // active-low pad reports, bit 0 = A
    logic        glitch_en = 1'b0;
    logic        gbit = 1'b1;
    logic [2:0]  pidx = 3'd0;

    int n_cmp = 0, n_err = 0, cyc = 0;
    int viol_hold = 0, viol_len = 0;

    nes_controller_poller #(.HALF_PERIOD(4), .POLL_PERIOD(100)) dut (
        .clk          (clk),
        .rst          (rst),
        .p1_data      (p1_data),
        .p2_data      (p2_data),
        .ctrl_latch   (ctrl_latch),
        .ctrl_pulse   (ctrl_pulse),
        .buttons      (buttons),
        .start_btn    (start_btn),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    // Pad model: latch reloads to bit 0, each pulse rise advances a bit.
    always @(posedge ctrl_latch or posedge ctrl_pulse) begin
        if (ctrl_latch) pidx = 3'd0;
        else            pidx = pidx + 3'd1;
    end

    always @(negedge clk) gbit = 1'($urandom);

    // P2 may be driven with garbage while the pulse line is high.
    always_comb begin
        p1_data = p1_rpt[pidx];
        p2_data = (glitch_en && ctrl_pulse) ? gbit : p2_rpt[pidx];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [0:11] model(input logic [7:0] r1, input logic [7:0] r2);
        int         ord [6] = '{6, 7, 4, 5, 0, 1};  // left right up down A B
        logic [0:11] m;
        logic [7:0]  r;
        for (int p = 0; p < 2; p++) begin
            r = (p == 0) ? r1 : r2;
            for (int j = 0; j < 6; j++) m[p*6 + j] = ~r[ord[j]];
        end
        return m;
    endfunction

    function automatic logic model_start(input logic [7:0] r1, input logic [7:0] r2);
        return !r1[3] || !r2[3];
    endfunction

    // Bus-shape monitor: latch 8 high, pulses 4 high, 7 pulses per strobe,
    // latch rises 100 apart, results move only with the strobe.
    logic [0:11] pb = '0;
    logic        ps = 1'b0, pl = 1'b0, pp = 1'b0;
    int          lat_len = 0, pul_len = 0, npul = 0, last_rise = -1;
    always @(posedge clk) begin
        cyc++;
        #1;
        if (rst) begin
            last_rise = -1; npul = 0; lat_len = 0; pul_len = 0;
        end else begin
            if ((buttons !== pb || start_btn !== ps) && !sample_valid) viol_hold++;
            if (ctrl_latch) begin
                if (!pl) begin
                    if (last_rise >= 0 && cyc - last_rise != 100) viol_len++;
                    last_rise = cyc; npul = 0; lat_len = 0;
                end
                lat_len++;
            end else if (pl && lat_len != 8) viol_len++;
            if (ctrl_pulse) begin
                if (!pp) begin npul++; pul_len = 0; end
                pul_len++;
            end else if (pp && pul_len != 4) viol_len++;
            if (sample_valid && npul != 7) viol_len++;
        end
        pb = buttons; ps = start_btn; pl = ctrl_latch; pp = ctrl_pulse;
    end

    task automatic wait_rise(output int t);
        logic prev;
        prev = ctrl_latch;
        t = -1;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            if (ctrl_latch && !prev) begin t = cyc; break; end
            prev = ctrl_latch;
        end
        if (t < 0) chk("latch_rise_tmo", 32'(t), 32'(0));
    endtask

    task automatic wait_sv(output int t);
        t = -1;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            if (sample_valid) begin t = cyc; break; end
        end
        if (t < 0) chk("strobe_tmo", 32'(t), 32'(0));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_latch"}, 32'(ctrl_latch), 32'(0));
        chk({tag, "_pulse"}, 32'(ctrl_pulse), 32'(0));
        chk({tag, "_btn"},   32'(buttons), 32'(0));
        chk({tag, "_start"}, 32'(start_btn), 32'(0));
        chk({tag, "_sv"},    32'(sample_valid), 32'(0));
    endtask

    initial begin
        int c, tl, ts, pv;
        rst = 1'b1; p1_rpt = 8'hFF; p2_rpt = 8'hFF;
        repeat (3) @(posedge clk);
        #1 chk_idle("rst");

        // Release reset: first latch after 100 edges, strobe 68 after it.
        @(negedge clk) rst = 1'b0;
        c = cyc;
        wait_rise(tl);
        chk("first_latch", 32'(tl - c), 32'(100));
        wait_sv(ts);
        chk("sv_after_latch", 32'(ts - tl), 32'(68));
        chk("idle_btn", 32'(buttons), 32'(model(p1_rpt, p2_rpt)));
        chk("idle_start", 32'(start_btn), 32'(0));

        // P1 A+Left, P2 Right+Start.
        p1_rpt = ~8'b0100_0001; p2_rpt = ~8'b1000_1000;
        pv = ts; wait_sv(ts);
        chk("pat_period", 32'(ts - pv), 32'(100));
        chk("pat_btn", 32'(buttons), 32'(12'b100010_010000));
        chk("pat_start", 32'(start_btn), 32'(1));

        // P1 lets go between polls.
        p1_rpt = 8'hFF;
        pv = ts; wait_sv(ts);
        chk("rel_period", 32'(ts - pv), 32'(100));
        chk("rel_btn", 32'(buttons), 32'(model(p1_rpt, p2_rpt)));
        chk("rel_start", 32'(start_btn), 32'(model_start(p1_rpt, p2_rpt)));

        // Reset in the LOW phase of bit 3.
        wait_rise(tl);
        repeat (33) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1 chk_idle("midrst");
        p1_rpt = 8'($urandom); p2_rpt = 8'($urandom);
        @(negedge clk) rst = 1'b0;
        c = cyc;
        wait_rise(tl);
        chk("rst_latch", 32'(tl - c), 32'(100));
        wait_sv(ts);
        chk("rst_btn", 32'(buttons), 32'(model(p1_rpt, p2_rpt)));
        chk("rst_start", 32'(start_btn), 32'(model_start(p1_rpt, p2_rpt)));

        // Back-to-back random polls, P2 glitching in HIGH on odd rounds.
        for (int i = 0; i < 6; i++) begin
            p1_rpt = 8'($urandom); p2_rpt = 8'($urandom);
            glitch_en = 1'(i % 2);
            pv = ts; wait_sv(ts);
            chk("rnd_period", 32'(ts - pv), 32'(100));
            chk("rnd_btn", 32'(buttons), 32'(model(p1_rpt, p2_rpt)));
            chk("rnd_start", 32'(start_btn), 32'(model_start(p1_rpt, p2_rpt)));
        end

        chk("hold_viol", 32'(viol_hold), 32'(0));
        chk("shape_viol", 32'(viol_len), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
